// File: rtl/mult_pkg.sv
// Shared widths, operand payload and FSM encoding for the multiplier operand issuer.
package mult_pkg;

    localparam int unsigned OPERAND_W = 16;
    localparam int unsigned PRODUCT_W = 32;
    localparam int unsigned PAIR_W    = 2 * OPERAND_W;

    typedef struct packed {
        logic [OPERAND_W-1:0] multiplicand;
        logic [OPERAND_W-1:0] multiplier;
    } operand_pair_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESULT = 2'd3;

endpackage

// File: rtl/operand_fifo.sv
// Operand-pair FIFO with registered full/empty flags; head is read combinationally.
module operand_fifo
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  operand_pair_t push_data,
    input  logic          pop,
    output operand_pair_t head_c,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    operand_pair_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    // Writes are refused when full and reads when empty, whatever the caller asks.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_operand_issuer.sv
// Issues buffered operand pairs to a multi-cycle multiplier one at a time, returning results in order.
// Define ISSUER_TIMEOUT_EN to add a WAIT-state watchdog that forces an error result.
module mult_operand_issuer
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_multiplicand,
    input  logic [OPERAND_W-1:0] in_multiplier,
    output logic                 mul_start,
    output logic [OPERAND_W-1:0] mul_multiplicand,
    output logic [OPERAND_W-1:0] mul_multiplier,
    input  logic                 mul_done,
    input  logic [PRODUCT_W-1:0] mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] out_product,
    output logic                 out_err
);

    state_t               state;
    state_t               state_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    operand_pair_t        in_pair;
    operand_pair_t        head;
    logic                 start_nxt;
    logic                 valid_nxt;
    logic                 err_nxt;
    logic [OPERAND_W-1:0] mcand_nxt;
    logic [OPERAND_W-1:0] mplier_nxt;
    logic [PRODUCT_W-1:0] product_nxt;
    logic                 timeout_c;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign in_pair  = {in_multiplicand, in_multiplier};

    operand_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_pair),
        .pop       (pop),
        .head_c    (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef ISSUER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;

    // Counts consecutive WAIT cycles; a completion in the final cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == ST_WAIT && !mul_done) begin
            wdog <= wdog + WD_W'(1);
        end else begin
            wdog <= '0;
        end
    end

    assign timeout_c = (state == ST_WAIT) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_c      = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        start_nxt   = 1'b0;
        mcand_nxt   = mul_multiplicand;
        mplier_nxt  = mul_multiplier;
        valid_nxt   = out_valid;
        product_nxt = out_product;
        err_nxt     = out_err;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_nxt  = ST_ISSUE;
                    start_nxt  = 1'b1;
                    mcand_nxt  = head.multiplicand;
                    mplier_nxt = head.multiplier;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    state_nxt   = ST_RESULT;
                    valid_nxt   = 1'b1;
                    product_nxt = mul_product;
                end else if (timeout_c) begin
                    state_nxt   = ST_RESULT;
                    valid_nxt   = 1'b1;
                    product_nxt = '0;
                    err_nxt     = 1'b1;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    // Chain straight into the next issue to avoid an idle bubble.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_nxt  = ST_ISSUE;
                        start_nxt  = 1'b1;
                        mcand_nxt  = head.multiplicand;
                        mplier_nxt = head.multiplier;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            out_err          <= 1'b0;
        end else begin
            state            <= state_nxt;
            mul_start        <= start_nxt;
            mul_multiplicand <= mcand_nxt;
            mul_multiplier   <= mplier_nxt;
            out_valid        <= valid_nxt;
            out_product      <= product_nxt;
            out_err          <= err_nxt;
        end
    end

endmodule

// File: doc/mult_operand_issuer.md
MULT_OPERAND_ISSUER -- requirements
Module: mult_operand_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state watchdog limit (used only with ISSUER_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  operand pair offered.
REQ-006 SHALL have port in_ready  out  1  FIFO not full.
REQ-007 SHALL have port in_multiplicand  in  16  operand A.
REQ-008 SHALL have port in_multiplier  in  16  operand B.
REQ-009 SHALL have port mul_start  out  1  one-cycle start pulse to multiplier datapath.
REQ-010 SHALL have port mul_multiplicand, mul_multiplier  out  16 each  operands to datapath.
REQ-011 SHALL have port mul_done  in  1  datapath completion.
REQ-012 SHALL have port mul_product  in  32  datapath result.
REQ-013 SHALL have port out_valid  out  1  result available.
REQ-014 SHALL have port out_ready  in  1  consumer accepts.
REQ-015 SHALL have ports out_product  out  32  and out_err  out  1  (watchdog expiry flag).

Function
REQ-016 Input transfer SHALL occur on an edge with in_valid && in_ready; the pair is written to FIFO tail.
REQ-017 in_ready SHALL equal !full; a write when full SHALL be impossible; simultaneous push and pop when full SHALL be allowed only via the pop freeing a slot next cycle (in_ready is not combinationally dependent on pop).
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESULT.
REQ-019 IDLE -> ISSUE when FIFO non-empty; pop head into operand registers on that edge.
REQ-020 ISSUE SHALL last exactly one cycle with mul_start=1, then -> WAIT.
REQ-021 mul_multiplicand/mul_multiplier SHALL stay stable from ISSUE until leaving WAIT.
REQ-022 WAIT -> RESULT on edge where mul_done=1; mul_product captured into out_product on that edge; mul_done outside WAIT SHALL be ignored.
REQ-023 RESULT SHALL hold out_valid=1 and out_product stable until out_ready=1; on that edge -> IDLE (or directly -> ISSUE with pop if FIFO non-empty).
REQ-024 Minimum latency: pair accepted on edge k into empty FIFO in IDLE -> mul_start high in cycle after edge k+1.
REQ-025 Results SHALL emerge in input order; one multiplication outstanding at most.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, FIFO empty, mul_start=0, out_valid=0, out_err=0, out_product=0, mul_* operands=0, watchdog=0.
REQ-028 Reset mid-operation SHALL abandon the in-flight multiply and discard FIFO contents; later mul_done SHALL be ignored.

Configuration
REQ-029 With ISSUER_TIMEOUT_EN defined: watchdog counts WAIT cycles; at TIMEOUT_CYCLES without mul_done -> RESULT with out_product=0, out_err=1 (cleared on out handshake).
REQ-030 Without ISSUER_TIMEOUT_EN: no watchdog logic, out_err tied 0, WAIT indefinite.

Structure
REQ-031 Shared package mult_pkg SHALL hold OPERAND_W=16, PRODUCT_W=32 and the FSM state typedef.
REQ-032 FIFO SHALL be sub-module operand_fifo (DEPTH, 32-bit data, sync reset).

Verification
REQ-033 Single pair 3x5, model datapath done 16 cycles after start with product -> out_product=15, out_valid one result, out_err=0.
REQ-034 Push 0xFFFF x 0xFFFF, 0x0000 x 0x1234, 0x00FF x 0x0100 back-to-back -> outputs 0xFFFE0001, 0x00000000, 0x0000FF00 in order.
REQ-035 Push DEPTH+1 pairs while datapath stalled -> in_ready=0 after DEPTH stored, no pair lost or duplicated.
REQ-036 out_ready held 0 for 10 cycles in RESULT -> out_product stable, no further mul_start.
REQ-037 Assert rst during WAIT, then pulse mul_done -> no out_valid, FIFO empty, state IDLE.
REQ-038 With ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=8, mul_done never asserted -> out_valid=1, out_err=1, out_product=0 after 8 WAIT cycles.
